// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - two-requester round-robin arbiter with bounded lock for one RAM port
//
// Shares a single synchronous RAM port (one-cycle read latency) between
// requesters r0 and r1. Grant is combinational in the request cycle and the
// access commits at the next rising edge.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req*/we*/lock*/addr*/wdata* requester access: request, write, keep-lock, address, write data
//   gnt*                        access accepted this cycle
//   rvalid*/rdata*              read data return, one cycle after a granted read
//   ram_addr/ram_din/ram_wen    to the RAM port (zero when nobody is granted)
//   ram_dout                    from the RAM port, valid one cycle after the address

module dpram_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    // Arbitration state
    logic       last_gnt;
    logic       lock_vld;
    logic       lock_idx;
    logic [3:0] lock_cnt;
    logic       rvalid0_q;
    logic       rvalid1_q;

    // Combinational winner
    logic       win_vld;
    logic       win_idx;
    logic       force_brk;
    logic       owner_req;
    logic       other_req;
    logic       win_we;
    logic       win_lock;

    always_comb begin
        win_vld   = 1'b0;
        win_idx   = 1'b0;
        force_brk = 1'b0;
        owner_req = lock_idx ? req1 : req0;
        other_req = lock_idx ? req0 : req1;
        if (reset) begin
            win_vld = 1'b0;
        end else if (lock_vld && owner_req && (lock_cnt < MAX_CNT)) begin
            win_vld = 1'b1;
            win_idx = lock_idx;
        end else if (lock_vld && (lock_cnt == MAX_CNT) && other_req) begin
            // Lock exhausted and the other side is waiting: hand over for one cycle.
            win_vld   = 1'b1;
            win_idx   = ~lock_idx;
            force_brk = 1'b1;
        end else if (req0 && req1) begin
            win_vld = 1'b1;
            win_idx = ~last_gnt;
        end else if (req0) begin
            win_vld = 1'b1;
            win_idx = 1'b0;
        end else if (req1) begin
            win_vld = 1'b1;
            win_idx = 1'b1;
        end
    end

    assign gnt0     = win_vld & ~win_idx;
    assign gnt1     = win_vld &  win_idx;
    assign win_we   = win_idx ? we1 : we0;
    assign win_lock = win_idx ? lock1 : lock0;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_wen  = 1'b0;
        if (win_vld) begin
            ram_addr = win_idx ? addr1 : addr0;
            ram_din  = win_idx ? wdata1 : wdata0;
            ram_wen  = win_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt  <= 1'b0;
            lock_vld  <= 1'b0;
            lock_idx  <= 1'b0;
            lock_cnt  <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~we0;
            rvalid1_q <= gnt1 & ~we1;
            if (win_vld) begin
                last_gnt <= win_idx;
            end
            if (force_brk) begin
                lock_vld <= 1'b0;
                lock_cnt <= 4'd0;
            end else if (win_vld && win_lock) begin
                if (lock_vld && (lock_idx == win_idx)) begin
                    if (lock_cnt < MAX_CNT) begin
                        lock_cnt <= lock_cnt + 4'd1;
                    end
                end else begin
                    lock_vld <= 1'b1;
                    lock_idx <= win_idx;
                    lock_cnt <= 4'd1;
                end
            end else begin
                // Owner dropped req or lock (or nobody asked to lock): release.
                lock_vld <= 1'b0;
                lock_cnt <= 4'd0;
            end
        end
    end

    // Gate with reset so a read granted just before reset never surfaces.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign rdata0  = rvalid0 ? ram_dout : '0;
    assign rdata1  = rvalid1 ? ram_dout : '0;

endmodule
